// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES constants and GF(2^8) helpers for the decryption datapath.
//   AES_POLY          : reduction constant of x^8 + x^4 + x^3 + x + 1
//   STATE_W           : width of the AES-128 state
//   NUM_ROWS/NUM_COLS : state geometry (4x4 bytes)
//   inv_mix_state_e   : FSM state encoding of the InvMixColumns stage
//   xtime, gf_mul9/b/d/e : constant multipliers for InvMixColumns
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam int         STATE_W  = 128;
    localparam int         NUM_ROWS = 4;
    localparam int         NUM_COLS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } inv_mix_state_e;

    // Multiply by {02}; the reduction folds bit 7 back in so nothing
    // carries out of the byte.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    // {09} = x8 ^ x
    function automatic logic [7:0] gf_mul9(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x;
    endfunction

    // {0b} = x8 ^ x2 ^ x
    function automatic logic [7:0] gf_mulb(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ x;
    endfunction

    // {0d} = x8 ^ x4 ^ x
    function automatic logic [7:0] gf_muld(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    // {0e} = x8 ^ x4 ^ x2
    function automatic logic [7:0] gf_mule(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/aes_inv_mix_columns_if.sv
// ---------------------------------------------------------------------------
// aes_inv_mix_columns_if
// Level handshake between AddRoundKey (master) and InvMixColumns (slave).
//   finish_add     : master -> slave, add_mat valid and held while high
//   add_mat        : master -> slave, 128-bit state, byte s(r,c) at 32*r+8*c
//   finish_inv_mix : slave -> master, result complete
//   inv_mix_mat    : slave -> master, 128-bit result, same byte layout
// ---------------------------------------------------------------------------
interface aes_inv_mix_columns_if;
    import aes_pkg::*;

    logic               finish_add;
    logic [STATE_W-1:0] add_mat;
    logic               finish_inv_mix;
    logic [STATE_W-1:0] inv_mix_mat;

    modport master (
        output finish_add,
        output add_mat,
        input  finish_inv_mix,
        input  inv_mix_mat
    );

    modport slave (
        input  finish_add,
        input  add_mat,
        output finish_inv_mix,
        output inv_mix_mat
    );

endinterface

// File: rtl/aes_inv_mix_byte.sv
// ---------------------------------------------------------------------------
// aes_inv_mix_byte
// Combinational InvMixColumns for a single output byte.
//   col     : input  32-bit column, row r in col[8*r +: 8]
//   row_sel : input  output row 0..3
//   result  : output 0e*s(r) ^ 0b*s(r+1) ^ 0d*s(r+2) ^ 09*s(r+3), rows mod 4
// ---------------------------------------------------------------------------
module aes_inv_mix_byte
    import aes_pkg::*;
(
    input  logic [31:0] col,
    input  logic [1:0]  row_sel,
    output logic [7:0]  result
);

    logic [63:0] col_twice;
    logic [31:0] rot;

    // Every output row uses the same coefficient pattern on a rotated
    // column, so rotate by row_sel and apply one fixed expression.
    always_comb begin
        col_twice = {col, col};
        rot       = col_twice[{row_sel, 3'b000} +: 32];
        result    = gf_mule(rot[7:0])   ^ gf_mulb(rot[15:8]) ^
                    gf_muld(rot[23:16]) ^ gf_mul9(rot[31:24]);
    end

endmodule

// File: rtl/aes_inv_mix_columns.sv
// ---------------------------------------------------------------------------
// aes_inv_mix_columns
// Iterative InvMixColumns stage of the AES-128 decryption datapath.
// Captures the state on the first sampled-high finish_add, then produces
// one result byte per clock (row-fastest order) and raises finish_inv_mix.
//   clk : input  rising-edge clock
//   rst : input  asynchronous active-high reset
//   bus : slave modport of aes_inv_mix_columns_if
// Build option: AES_INV_MIX_COL_PAR_EN computes a whole column per clock
// (four compute edges instead of sixteen).
// ---------------------------------------------------------------------------
module aes_inv_mix_columns
    import aes_pkg::*;
(
    input logic                   clk,
    input logic                   rst,
    aes_inv_mix_columns_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] CALC = 2'(ST_CALC);
    localparam logic [1:0] DONE = 2'(ST_DONE);

`ifdef AES_INV_MIX_COL_PAR_EN
    localparam int IDX_W = 2;
`else
    localparam int IDX_W = 4;
`endif

    logic [1:0]         state;
    logic [IDX_W-1:0]   idx;
    logic [STATE_W-1:0] cap_mat;
    logic [STATE_W-1:0] res_mat;
    logic               done_flag;
    logic [1:0]         col_sel;
    logic [31:0]        cap_col;

`ifdef AES_INV_MIX_COL_PAR_EN
    assign col_sel = idx;
`else
    assign col_sel = idx[3:2];
`endif

    // Gather the captured column being worked on into row-ordered bytes.
    always_comb begin
        cap_col[7:0]   = cap_mat[{2'd0, col_sel, 3'b000} +: 8];
        cap_col[15:8]  = cap_mat[{2'd1, col_sel, 3'b000} +: 8];
        cap_col[23:16] = cap_mat[{2'd2, col_sel, 3'b000} +: 8];
        cap_col[31:24] = cap_mat[{2'd3, col_sel, 3'b000} +: 8];
    end

`ifdef AES_INV_MIX_COL_PAR_EN
    logic [7:0] byte_out [NUM_ROWS];

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        aes_inv_mix_byte u_byte (
            .col     (cap_col),
            .row_sel (2'(r)),
            .result  (byte_out[r])
        );
    end
`else
    logic [7:0] byte_out;

    aes_inv_mix_byte u_byte (
        .col     (cap_col),
        .row_sel (idx[1:0]),
        .result  (byte_out)
    );
`endif

    // Dropping finish_add wins over every state so an in-flight column is
    // abandoned cleanly; the captured state is left alone since it is
    // reloaded on the next IDLE->CALC entry anyway. idx wraps to zero on
    // the last compute edge, which is also the CALC->DONE edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cap_mat   <= '0;
            res_mat   <= '0;
            done_flag <= 1'b0;
        end else if (!bus.finish_add) begin
            state     <= IDLE;
            idx       <= '0;
            res_mat   <= '0;
            done_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cap_mat <= bus.add_mat;
                    idx     <= '0;
                    res_mat <= '0;
                    state   <= CALC;
                end
                CALC: begin
`ifdef AES_INV_MIX_COL_PAR_EN
                    for (int r = 0; r < NUM_ROWS; r++) begin
                        res_mat[{r[1:0], idx, 3'b000} +: 8] <= byte_out[r];
                    end
`else
                    res_mat[{idx[1:0], idx[3:2], 3'b000} +: 8] <= byte_out;
`endif
                    idx <= idx + 1'b1;
                    if (&idx) begin
                        done_flag <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done_flag <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.finish_inv_mix = done_flag;
    assign bus.inv_mix_mat    = res_mat;

endmodule

// File: tb/tb_aes_inv_mix_columns.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_mix_columns
// Directed and round-trip bench for aes_inv_mix_columns: known-answer
// columns, handshake latency, DONE hold, abort, async reset mid-run,
// input change after capture, and MixColumns -> InvMixColumns round trips.
// ---------------------------------------------------------------------------
module tb_aes_inv_mix_columns;

`ifdef AES_INV_MIX_COL_PAR_EN
    localparam int LATENCY    = 5;
    localparam int ABORT_EDGE = 3;
`else
    localparam int LATENCY    = 17;
    localparam int ABORT_EDGE = 7;
`endif
    localparam int WAIT_LIMIT = 40;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    aes_inv_mix_columns_if bus_if ();

    aes_inv_mix_columns dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] got,
                               input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Place one column (rows 0..3) into a state word.
    function automatic logic [127:0] set_col(input logic [127:0] m, input int c,
                                             input logic [7:0] r0, input logic [7:0] r1,
                                             input logic [7:0] r2, input logic [7:0] r3);
        logic [127:0] t;
        t = m;
        t[32*0 + 8*c +: 8] = r0;
        t[32*1 + 8*c +: 8] = r1;
        t[32*2 + 8*c +: 8] = r2;
        t[32*3 + 8*c +: 8] = r3;
        return t;
    endfunction

    function automatic logic [7:0] mul2(input logic [7:0] x);
        return x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    endfunction

    // Forward MixColumns reference: matrix {02,03,01,01}.
    function automatic logic [127:0] mix_state(input logic [127:0] m);
        logic [127:0] o;
        logic [7:0]   s0, s1, s2, s3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            s0 = m[0  + 8*c +: 8];
            s1 = m[32 + 8*c +: 8];
            s2 = m[64 + 8*c +: 8];
            s3 = m[96 + 8*c +: 8];
            o[0  + 8*c +: 8] = mul2(s0) ^ mul2(s1) ^ s1 ^ s2 ^ s3;
            o[32 + 8*c +: 8] = s0 ^ mul2(s1) ^ mul2(s2) ^ s2 ^ s3;
            o[64 + 8*c +: 8] = s0 ^ s1 ^ mul2(s2) ^ mul2(s3) ^ s3;
            o[96 + 8*c +: 8] = mul2(s0) ^ s0 ^ s1 ^ s2 ^ mul2(s3);
        end
        return o;
    endfunction

    // Present a state with finish_add high and count edges until done.
    task automatic applyStimulus(input logic [127:0] mat, output int cycles);
        @(negedge clk);
        bus_if.add_mat    = mat;
        bus_if.finish_add = 1'b1;
        cycles = 0;
        while (cycles < WAIT_LIMIT) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus_if.finish_inv_mix) break;
        end
    endtask

    // Drop the handshake and confirm the outputs clear on the next edge.
    task automatic dropHandshake(input string tag);
        @(negedge clk);
        bus_if.finish_add = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, "_drop_flag"}, 128'(bus_if.finish_inv_mix), 128'd0);
        checkOutput({tag, "_drop_mat"}, bus_if.inv_mix_mat, 128'd0);
    endtask

    logic [127:0] vec1_in, vec1_exp, vec2_in, vec2_exp, orig;
    int           cyc;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_if.finish_add = 1'b0;
        bus_if.add_mat    = '0;

        vec1_in  = set_col(128'd0, 0, 8'h8e, 8'h4d, 8'ha1, 8'hbc);
        vec1_exp = set_col(128'd0, 0, 8'hdb, 8'h13, 8'h53, 8'h45);

        vec2_in  = set_col(128'd0,   0, 8'h9f, 8'hdc, 8'h58, 8'h9d);
        vec2_in  = set_col(vec2_in,  1, 8'hd5, 8'hd5, 8'hd7, 8'hd6);
        vec2_in  = set_col(vec2_in,  2, 8'h4d, 8'h7e, 8'hbd, 8'hf8);
        vec2_in  = set_col(vec2_in,  3, 8'h01, 8'h01, 8'h01, 8'h01);
        vec2_exp = set_col(128'd0,   0, 8'hf2, 8'h0a, 8'h22, 8'h5c);
        vec2_exp = set_col(vec2_exp, 1, 8'hd4, 8'hd4, 8'hd4, 8'hd5);
        vec2_exp = set_col(vec2_exp, 2, 8'h2d, 8'h26, 8'h31, 8'h4c);
        vec2_exp = set_col(vec2_exp, 3, 8'h01, 8'h01, 8'h01, 8'h01);

        #12;
        checkOutput("reset_flag", 128'(bus_if.finish_inv_mix), 128'd0);
        checkOutput("reset_mat", bus_if.inv_mix_mat, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Known-answer column, latency and hold in DONE.
        applyStimulus(vec1_in, cyc);
        checkOutput("kat1_latency", 128'(cyc), 128'(LATENCY));
        checkOutput("kat1_flag", 128'(bus_if.finish_inv_mix), 128'd1);
        checkOutput("kat1_mat", bus_if.inv_mix_mat, vec1_exp);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("kat1_hold_flag", 128'(bus_if.finish_inv_mix), 128'd1);
        checkOutput("kat1_hold_mat", bus_if.inv_mix_mat, vec1_exp);
        dropHandshake("kat1");

        // Full-state known answer.
        applyStimulus(vec2_in, cyc);
        checkOutput("kat2_latency", 128'(cyc), 128'(LATENCY));
        checkOutput("kat2_mat", bus_if.inv_mix_mat, vec2_exp);
        dropHandshake("kat2");

        // Abort mid-computation, then a full run with new data.
        @(negedge clk);
        bus_if.add_mat    = vec1_in;
        bus_if.finish_add = 1'b1;
        repeat (ABORT_EDGE) @(posedge clk);
        #1;
        checkOutput("abort_pre_flag", 128'(bus_if.finish_inv_mix), 128'd0);
        dropHandshake("abort");
        applyStimulus(vec2_in, cyc);
        checkOutput("abort_rerun_latency", 128'(cyc), 128'(LATENCY));
        checkOutput("abort_rerun_mat", bus_if.inv_mix_mat, vec2_exp);
        dropHandshake("abort_rerun");

        // Asynchronous reset between edges while computing.
        @(negedge clk);
        bus_if.add_mat    = vec2_in;
        bus_if.finish_add = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_flag", 128'(bus_if.finish_inv_mix), 128'd0);
        checkOutput("rst_mid_mat", bus_if.inv_mix_mat, 128'd0);
        @(negedge clk);
        bus_if.add_mat = vec1_in;
        rst = 1'b0;
        cyc = 0;
        while (cyc < WAIT_LIMIT) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus_if.finish_inv_mix) break;
        end
        checkOutput("rst_rerun_latency", 128'(cyc), 128'(LATENCY));
        checkOutput("rst_rerun_mat", bus_if.inv_mix_mat, vec1_exp);
        dropHandshake("rst_rerun");

        // Input changes after capture must not affect the result.
        @(negedge clk);
        bus_if.add_mat    = vec2_in;
        bus_if.finish_add = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus_if.add_mat = ~vec2_in;
        cyc = 2;
        while (cyc < WAIT_LIMIT) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus_if.finish_inv_mix) break;
        end
        checkOutput("hold_in_latency", 128'(cyc), 128'(LATENCY));
        checkOutput("hold_in_mat", bus_if.inv_mix_mat, vec2_exp);
        dropHandshake("hold_in");

        // Round trip through the forward MixColumns model.
        for (int n = 0; n < 1000; n++) begin
            orig = {$urandom(), $urandom(), $urandom(), $urandom()};
            applyStimulus(mix_state(orig), cyc);
            checkOutput("round_trip_latency", 128'(cyc), 128'(LATENCY));
            checkOutput("round_trip_mat", bus_if.inv_mix_mat, orig);
            @(negedge clk);
            bus_if.finish_add = 1'b0;
            @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_inv_mix_columns.md
# aes_inv_mix_columns

Iterative InvMixColumns stage for the AES-128 decryption datapath, the inverse of the encryption-side MixColumns stage. It is enabled by the preceding AddRoundKey stage through a level handshake. It captures the 128-bit state, then computes one output byte per clock by GF(2^8) multiplication with the inverse matrix {0e,0b,0d,09}. It raises `finish_inv_mix` when the full state is ready for the next InvShiftRows stage.

## Interface
Parameters:
- none; all widths are fixed by AES-128.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `finish_add` input 1: level enable from AddRoundKey; high means `add_mat` is valid and held.
- `add_mat` input 128: input state. Byte s(r,c) = `add_mat[32*r + 8*c +: 8]`, with r = row 0..3 and c = column 0..3.
- `finish_inv_mix` output 1: registered; high while the result is complete and `finish_add` remains high.
- `inv_mix_mat` output 128: result state, same byte layout as `add_mat`.

## Operation
- Arithmetic:
  - Per column c, the output bytes are:
    - o0 = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3
    - o1 = 09·s0 ^ 0e·s1 ^ 0b·s2 ^ 0d·s3
    - o2 = 0d·s0 ^ 09·s1 ^ 0e·s2 ^ 0b·s3
    - o3 = 0b·s0 ^ 0d·s1 ^ 09·s2 ^ 0e·s3
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
  - 09 = x8^x; 0b = x8^x2^x; 0d = x8^x4^x; 0e = x8^x4^x2, where x2/x4/x8 are successive xtime.
  - All values are 8-bit; there is no carry beyond bit 7.
- FSM states: IDLE, CALC, DONE.
  - IDLE: outputs as at reset. When `finish_add`=1: capture `add_mat` into the internal state register, set `idx`=0, clear the result register, go to CALC.
  - CALC: each edge writes result byte (row = idx[1:0], col = idx[3:2]), computed from the captured column, then `idx` += 1. The edge that writes idx 15 sets `finish_inv_mix`=1 and goes to DONE. Byte order is row-fastest: col0 rows 0..3, then col1, and so on.
  - DONE: hold `inv_mix_mat` and `finish_inv_mix`=1 while `finish_add`=1.
- `finish_add` low in any state: the next edge returns to IDLE, clears `finish_inv_mix`, the result register and `idx`. This aborts a CALC mid-run.
- `add_mat` changes after capture are ignored until the next IDLE→CALC entry.
- A new operation requires `finish_add` to drop for at least one edge.
- `idx` is 4 bits. Its wrap 15→0 coincides with the CALC→DONE transition and is never used as a new byte index.

## Timing
- Reset values: `finish_inv_mix`=0, `inv_mix_mat`=128'h0, state=IDLE, `idx`=0, internal state register=0.
- Reset is effective immediately on assertion, including mid-CALC.
- Latency:
  - edge E0: capture (`finish_add` sampled high in IDLE).
  - edges E1..E16: compute bytes 0..15.
  - `finish_inv_mix` is high after E16, i.e. 17 cycles from the first sampled-high `finish_add`.
- `inv_mix_mat` is guaranteed correct only while `finish_inv_mix`=1. Partial bytes are visible during CALC.
- Deassertion of `finish_add` in DONE: `finish_inv_mix` falls on the next edge.

## Configuration
- `AES_INV_MIX_COL_PAR_EN` defined:
  - CALC computes all four bytes of column `idx[1:0]` per edge.
  - 2-bit `idx`; four compute edges; `finish_inv_mix` high after E4 (latency 5 cycles).
- Undefined: byte-serial behaviour as specified above (latency 17 cycles).
- Handshake, reset and abort behaviour are identical in both modes.

## Structure
- Shared package `aes_pkg`:
  - `xtime` function.
  - `AES_POLY` = 8'h1B.
  - state-width constant (128) and row/column counts.
  - FSM state enum type.
  - `gf_mul9`/`gf_mulb`/`gf_muld`/`gf_mule` helper functions.
- Sub-module `aes_inv_mix_byte`: combinational; inputs a 32-bit column and 2-bit row select, output one byte.
  - One instance in byte-serial mode; four instances (row selects 0..3) under `AES_INV_MIX_COL_PAR_EN`.

## Test plan
- FIPS-197 column: column 0 of `add_mat` = rows (8e,4d,a1,bc), other columns zero → column 0 of `inv_mix_mat` = (db,13,53,45), others 00. `finish_inv_mix` rises 17 cycles after `finish_add` (5 with the macro).
- Full state, columns (9f,dc,58,9d), (d5,d5,d7,d6), (4d,7e,bd,f8), (01,01,01,01) → columns (f2,0a,22,5c), (d4,d4,d4,d5), (2d,26,31,4c), (01,01,01,01).
- Round trip: random 1000 states through the reference MixColumns model, then this block → output equals the original state.
- Abort: drop `finish_add` at compute edge E7 → `finish_inv_mix` stays 0, `inv_mix_mat`=0 after the next edge. Re-assert with new data → correct result after a full latency.
- Async reset mid-CALC: assert `rst` between edges → outputs 0 immediately. After release with `finish_add` high → normal 17-cycle completion.
- Input change after capture: alter `add_mat` during CALC → result reflects the captured value only.
